muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle sequencer for the MUL (OP=3'b101) and DIV (OP=3'b110) codes issued by ALU control.
//  - Runs an iterative radix-2 shift-add multiply or a restoring divide.
//  - Sits beside the single-cycle ALU; the pipeline stalls on BUSY and captures HI/LO on DONE.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are WIDTH each; iteration count = WIDTH
// PORTS
//  CLK          in   1      clock, rising edge
//  RST          in   1      synchronous reset, active-high
//  START        in   1      request; sampled only in IDLE/FINISH
//  OP           in   3      ALU op code; 3'b101=mul, 3'b110=div; all other codes are ignored
//  A            in   WIDTH  multiplicand / dividend
//  B            in   WIDTH  multiplier / divisor
//  BUSY         out  1      high while in RUN or FIXUP
//  DONE         out  1      one-cycle pulse; HI/LO valid on the same cycle
//  HI           out  WIDTH  mul: product[2W-1:W]; div: remainder
//  LO           out  WIDTH  mul: product[W-1:0]; div: quotient
//  DIV_BY_ZERO  out  1      set with DONE for a div with B==0; held until next accepted START
// BEHAVIOUR
//  - Reset (sync, RST=1 at an edge): state=IDLE, BUSY=0, DONE=0, HI=0, LO=0, DIV_BY_ZERO=0.
//    RST dominates every other input. Reset mid-operation aborts the op and discards partial results.
//  - FSM states:
//    - IDLE: START & OP in {101,110} -> latch A,B,OP; clear DIV_BY_ZERO; count=0; go RUN.
//    - RUN: one iteration per cycle; count increments; at count==WIDTH-1 go FINISH
//      (or FIXUP when the macro is defined).
//    - FIXUP: macro builds only; applies sign correction, then goes FINISH.
//    - FINISH: DONE=1 for exactly this cycle; HI/LO loaded; a new START is accepted here (back-to-back),
//      else go IDLE.
//  - Illegal OP with START in IDLE/FINISH: ignored; state, HI and LO unchanged.
//  - START while BUSY=1: ignored, no queuing. A/B/OP changes during RUN have no effect.
//  - Cycle n = n-th rising edge after the edge that accepted START.
//    - BUSY=1 in cycles 1..WIDTH; DONE=1 at cycle WIDTH+1 (WIDTH+2 with the macro).
//    - Next START may be accepted at the DONE edge.
//  - Multiply: unsigned, 2W-bit accumulator; product never overflows.
//  - Divide: unsigned restoring; partial remainder is W+1 bits.
//  - Div by zero: detected at accept; skip RUN; FINISH at cycle 1 (DONE=1, BUSY never asserted).
//    Result: LO={WIDTH{1'b1}}, HI=A, DIV_BY_ZERO=1.
//  - HI/LO hold their last result from FINISH until the next FINISH or reset; they do not change during RUN.
//  - Multiply with A==0 or B==0 still takes the full latency (no early termination).
// CONFIGURATION
//  MULDIV_SIGNED_EN defined:
//  - Operands are two's complement. Magnitudes are taken at accept and sign fixed in FIXUP (+1 cycle latency).
//  - Quotient truncates toward zero; remainder takes the dividend's sign.
//  - Div by zero gives the same result as unsigned: LO=all-ones, HI=A, DIV_BY_ZERO=1.
//  - Most-negative / -1: LO=A (most-negative), HI=0, no flag.
//  MULDIV_SIGNED_EN undefined: all operations unsigned; no FIXUP state; latency WIDTH+1.
// TESTING (WIDTH=32)
//  - mul A=7 B=6 -> DONE at cycle 33, LO=42, HI=0, DIV_BY_ZERO=0; BUSY high cycles 1..32.
//  - mul A=B=0xFFFFFFFF (unsigned) -> HI=0xFFFFFFFE, LO=0x00000001.
//  - div A=100 B=7 -> LO=14, HI=2; a START with OP=3'b000 during RUN is ignored and result is unchanged.
//  - div A=5 B=0 -> DONE at cycle 1, BUSY stays 0, LO=0xFFFFFFFF, HI=5, DIV_BY_ZERO=1.
//  - RST=1 at cycle 10 of a mul -> next cycle IDLE, BUSY=0, HI=LO=0; no DONE pulse.
//    A fresh mul 3*4 then gives LO=12.
//  - MULDIV_SIGNED_EN: div A=-7 B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, DONE at cycle 34.
//    mul A=-3 B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/DIV sequencer: radix-2 shift-add multiply and restoring divide.
// Define MULDIV_SIGNED_EN for two's-complement operands (adds a FIXUP cycle).
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             DIV_BY_ZERO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int W2 = 2 * WIDTH;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FIXUP  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             isDiv_q, isDiv_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  logic             opLegal, accept;
  logic [WIDTH-1:0] magA, magB;
  logic [WIDTH:0]   mulSum;
  logic [W2-1:0]    mulNext;
  logic [WIDTH:0]   divShift;
  logic             divFits;
  logic [WIDTH-1:0] remNext, quoNext;

  assign opLegal = (OP == OP_MUL) || (OP == OP_DIV);
  assign accept  = START && opLegal && ((state_q == S_IDLE) || (state_q == S_FINISH));

`ifdef MULDIV_SIGNED_EN
  logic          negQuo_q, negQuo_d;
  logic          negRem_q, negRem_d;
  logic [W2-1:0] fixedProd;

  assign magA      = A[WIDTH-1] ? ((~A) + WIDTH'(1)) : A;
  assign magB      = B[WIDTH-1] ? ((~B) + WIDTH'(1)) : B;
  assign fixedProd = negQuo_q ? ((~acc_q) + W2'(1)) : acc_q;
`else
  assign magA = A;
  assign magB = B;
`endif

  // Multiply keeps {partial product, remaining multiplier bits} in acc_q;
  // divide keeps the dividend/quotient shift register in acc_q's low half.
  assign mulSum   = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opB_q} : '0);
  assign mulNext  = {mulSum, acc_q[WIDTH-1:1]};
  assign divShift = {rem_q, acc_q[WIDTH-1]};
  assign divFits  = divShift >= {1'b0, opB_q};
  assign remNext  = divFits ? WIDTH'(divShift - {1'b0, opB_q}) : divShift[WIDTH-1:0];
  assign quoNext  = {acc_q[WIDTH-2:0], divFits};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    isDiv_d = isDiv_q;
    opB_d   = opB_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
`ifdef MULDIV_SIGNED_EN
    negQuo_d = negQuo_q;
    negRem_d = negRem_q;
`endif
    case (state_q)
      S_IDLE, S_FINISH: begin
        if (accept) begin
          isDiv_d = (OP == OP_DIV);
          dbz_d   = 1'b0;
          count_d = '0;
          opB_d   = magB;
          acc_d   = {{WIDTH{1'b0}}, magA};
          rem_d   = '0;
`ifdef MULDIV_SIGNED_EN
          negQuo_d = A[WIDTH-1] ^ B[WIDTH-1];
          negRem_d = A[WIDTH-1];
`endif
          // A zero divisor is resolved immediately without iterating.
          if ((OP == OP_DIV) && (B == '0)) begin
            state_d = S_FINISH;
            hi_d    = A;
            lo_d    = '1;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        count_d = count_q + CW'(1);
        if (isDiv_q) begin
          acc_d = {acc_q[W2-1:WIDTH], quoNext};
          rem_d = remNext;
        end else begin
          acc_d = mulNext;
        end
        if (count_q == CW'(WIDTH - 1)) begin
`ifdef MULDIV_SIGNED_EN
          state_d = S_FIXUP;
`else
          state_d = S_FINISH;
          hi_d    = isDiv_q ? remNext : mulNext[W2-1:WIDTH];
          lo_d    = isDiv_q ? quoNext : mulNext[WIDTH-1:0];
`endif
        end
      end
`ifdef MULDIV_SIGNED_EN
      S_FIXUP: begin
        state_d = S_FINISH;
        if (isDiv_q) begin
          hi_d = negRem_q ? ((~rem_q) + WIDTH'(1)) : rem_q;
          lo_d = negQuo_q ? ((~acc_q[WIDTH-1:0]) + WIDTH'(1)) : acc_q[WIDTH-1:0];
        end else begin
          hi_d = fixedProd[W2-1:WIDTH];
          lo_d = fixedProd[WIDTH-1:0];
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      count_q <= '0;
      isDiv_q <= 1'b0;
      opB_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      negQuo_q <= 1'b0;
      negRem_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      isDiv_q <= isDiv_d;
      opB_q   <= opB_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
`ifdef MULDIV_SIGNED_EN
      negQuo_q <= negQuo_d;
      negRem_q <= negRem_d;
`endif
    end
  end

  assign BUSY        = (state_q == S_RUN) || (state_q == S_FIXUP);
  assign DONE        = (state_q == S_FINISH);
  assign HI          = hi_q;
  assign LO          = lo_q;
  assign DIV_BY_ZERO = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a queue of expected results.
// Expectations follow MULDIV_SIGNED_EN when it is defined for the build.
module tb_muldiv_sequencer;
  localparam int WIDTH = 32;
`ifdef MULDIV_SIGNED_EN
  localparam int LAT = WIDTH + 2;
`else
  localparam int LAT = WIDTH + 1;
`endif
  localparam logic [2:0] MUL = 3'b101;
  localparam logic [2:0] DIV = 3'b110;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [2:0]  OP = 3'b000;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        BUSY, DONE, DIV_BY_ZERO;
  logic [31:0] HI, LO;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    logic [15:0] lat;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] lastHi = '0;
  logic [31:0] lastLo = '0;

  muldiv_sequencer #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OP(OP), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .HI(HI), .LO(LO), .DIV_BY_ZERO(DIV_BY_ZERO)
  );

  always #5 CLK = ~CLK;

  // Reference arithmetic, independent of the iterative datapath.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    e.dbz = 1'b0;
    e.lat = 16'(LAT);
    e.hi  = '0;
    e.lo  = '0;
    if (op == DIV && b == 32'd0) begin
      e.hi = a; e.lo = '1; e.dbz = 1'b1; e.lat = 16'd1;
    end else if (op == MUL) begin
`ifdef MULDIV_SIGNED_EN
      p = 64'(longint'($signed(a)) * longint'($signed(b)));
`else
      p = {32'd0, a} * {32'd0, b};
`endif
      e.hi = p[63:32]; e.lo = p[31:0];
    end else begin
`ifdef MULDIV_SIGNED_EN
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
        e.lo = a; e.hi = '0;
      end else begin
        e.lo = 32'($signed(a) / $signed(b));
        e.hi = 32'($signed(a) % $signed(b));
      end
`else
      e.lo = a / b; e.hi = a % b;
`endif
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one START cycle; the edge that samples it is cycle 0.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input bit push);
    START = 1'b1; OP = op; A = a; B = b;
    if (push) sb.push_back(model(op, a, b));
    tick();
    START = 1'b0;
  endtask

  // Wait (bounded) for DONE, then compare latency, BUSY span and results.
  task automatic checkOutput(input string tag, input int startN);
    int   n;
    int   busyCnt;
    int   holdBad;
    exp_t e;
    n = startN; busyCnt = startN - 1; holdBad = 0;
    while (DONE !== 1'b1 && n <= LAT + 20) begin
      if (BUSY === 1'b1) busyCnt++;
      if (HI !== lastHi || LO !== lastLo) holdBad++;
      tick();
      n++;
    end
    checkVal({tag, "_done"}, 64'(DONE), 64'd1);
    checkVal({tag, "_sbsize"}, 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkVal({tag, "_lat"}, 64'(n), 64'(e.lat));
      checkVal({tag, "_busycnt"}, 64'(busyCnt), 64'(e.lat - 16'd1));
      checkVal({tag, "_hold"}, 64'(holdBad), 64'd0);
      checkVal({tag, "_hi"}, 64'(HI), 64'(e.hi));
      checkVal({tag, "_lo"}, 64'(LO), 64'(e.lo));
      checkVal({tag, "_dbz"}, 64'(DIV_BY_ZERO), 64'(e.dbz));
      checkVal({tag, "_busy_at_done"}, 64'(BUSY), 64'd0);
      lastHi = e.hi; lastLo = e.lo;
    end
  endtask

  initial begin
    int doneCnt;
    logic [31:0] ra, rb;
    logic [2:0]  rop;

    tick(); tick();
    RST = 1'b0;
    checkVal("rst_busy", 64'(BUSY), 64'd0);
    checkVal("rst_done", 64'(DONE), 64'd0);
    checkVal("rst_hi", 64'(HI), 64'd0);
    checkVal("rst_lo", 64'(LO), 64'd0);
    checkVal("rst_dbz", 64'(DIV_BY_ZERO), 64'd0);

    applyStimulus(MUL, 32'd7, 32'd6, 1);
    checkOutput("mul7x6", 1);
    tick();
    checkVal("done_pulse", 64'(DONE), 64'd0);

    applyStimulus(MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    checkOutput("mul_max", 1);
    tick();

    applyStimulus(3'b011, 32'd9, 32'd9, 0);
    checkVal("illegal_busy", 64'(BUSY), 64'd0);
    tick(); tick();
    checkVal("illegal_done", 64'(DONE), 64'd0);
    checkVal("illegal_hi", 64'(HI), 64'(lastHi));
    checkVal("illegal_lo", 64'(LO), 64'(lastLo));

    // Requests and operand changes during RUN must not disturb the divide.
    applyStimulus(DIV, 32'd100, 32'd7, 1);
    tick(); tick(); tick();
    START = 1'b1; OP = 3'b000; A = 32'd1; B = 32'd1;
    tick();
    OP = MUL;
    checkVal("run_busy", 64'(BUSY), 64'd1);
    tick();
    START = 1'b0; A = 32'd55; B = 32'd3;
    checkOutput("div100_7", 6);
    tick();

    applyStimulus(DIV, 32'd5, 32'd0, 1);
    checkOutput("div_by_zero", 1);
    tick(); tick(); tick();
    checkVal("dbz_held", 64'(DIV_BY_ZERO), 64'd1);
    applyStimulus(MUL, 32'd0, 32'd12345, 1);
    checkVal("dbz_clear", 64'(DIV_BY_ZERO), 64'd0);
    checkOutput("mul_zero", 1);
    tick();

    // Back-to-back: the next START is accepted on the DONE edge.
    applyStimulus(DIV, 32'd1000, 32'd33, 1);
    checkOutput("b2b_div", 1);
    applyStimulus(MUL, 32'hDEAD, 32'hBEEF, 1);
    checkOutput("b2b_mul", 1);
    tick();

    applyStimulus(MUL, 32'h1234, 32'h55, 1);
    repeat (8) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    sb.delete();
    lastHi = '0; lastLo = '0;
    checkVal("abort_busy", 64'(BUSY), 64'd0);
    checkVal("abort_hi", 64'(HI), 64'd0);
    checkVal("abort_lo", 64'(LO), 64'd0);
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (DONE === 1'b1) doneCnt++;
      tick();
    end
    checkVal("abort_no_done", 64'(doneCnt), 64'd0);
    applyStimulus(MUL, 32'd3, 32'd4, 1);
    checkOutput("mul3x4", 1);
    tick();

    applyStimulus(DIV, 32'hFFFFFFF9, 32'd2, 1);
    checkOutput("div_neg7_2", 1);
    tick();
    applyStimulus(MUL, 32'hFFFFFFFD, 32'd5, 1);
    checkOutput("mul_neg3_5", 1);
    tick();
    applyStimulus(DIV, 32'h80000000, 32'hFFFFFFFF, 1);
    checkOutput("div_minneg", 1);
    tick();

    for (int i = 0; i < 4; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = ($urandom_range(0, 1) == 0) ? MUL : DIV;
      applyStimulus(rop, ra, rb, 1);
      checkOutput($sformatf("rand%0d", i), 1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
